// File: rtl/pluse_seq_ctrl.sv
// CPMG echo-train sequencer: one 90 deg excitation followed by echo_num 180 deg
// refocusing pulses on PLUSE, with tau spacing and an acquisition window per echo.
module pluse_seq_ctrl #(
   parameter int QQ_W   = 16,
   parameter int CNT_W  = 16,
   parameter int TO_CYC = 8
) (
   input  logic             clk_sys,
   input  logic             rst,
   input  logic             start,
   input  logic             abort,
   input  logic [QQ_W-1:0]  t90_len,
   input  logic [QQ_W-1:0]  t180_len,
   input  logic [7:0]       bri_cfg,
   input  logic [CNT_W-1:0] tau,
   input  logic [CNT_W-1:0] echo_num,
   input  logic             pulse_busy,
   output logic             pluse_load,
   output logic             state_start,
   output logic             phase,
   output logic [QQ_W-1:0]  qq_para,
   output logic [7:0]       bri_para,
   output logic             acq_win,
   output logic             busy,
   output logic             done,
   output logic             err,
   output logic [CNT_W-1:0] echo_cnt
);

   localparam int TO_W = $clog2(TO_CYC + 1);

   typedef enum logic [2:0] {
      S_IDLE, S_LOAD, S_FIRE, S_WAIT_HI, S_WAIT_LO, S_DELAY, S_ECHO, S_FIN
   } state_t;

   state_t            state, next_state;
   logic [QQ_W-1:0]   t180_q;
   logic [7:0]        bri_q;
   logic [CNT_W-1:0]  tau_q, num_q;
   logic              is180;
   logic [CNT_W:0]    dly_cnt;
   logic [TO_W-1:0]   to_cnt;
   logic [CNT_W-1:0]  tau_eff;
   logic [CNT_W:0]    tau2;
   logic              cnt_last;

   // tau=0 behaves as tau=1; 2*tau carries into the extra counter bit
   assign tau_eff  = (tau_q == '0) ? CNT_W'(1) : tau_q;
   assign tau2     = {tau_eff, 1'b0};
   assign cnt_last = (dly_cnt <= (CNT_W+1)'(1));

   always_ff @(posedge clk_sys) begin
      if (rst) state <= S_IDLE;
      else     state <= next_state;
   end

   always_comb begin
      // NOTE: default assignment first so no path through this block infers a latch.
      next_state = state;
      case (state)
         S_IDLE:    if (start) next_state = S_LOAD;
         S_LOAD:    next_state = S_FIRE;
         S_FIRE:    next_state = S_WAIT_HI;
         S_WAIT_HI: begin
            if (pulse_busy)                     next_state = S_WAIT_LO;
            else if (to_cnt <= TO_W'(1))        next_state = S_FIN;
         end
         S_WAIT_LO: begin
            if (!pulse_busy) begin
               if (is180)               next_state = S_ECHO;
               else if (num_q == '0)    next_state = S_FIN;
               else                     next_state = S_DELAY;
            end
         end
         S_DELAY:   if (cnt_last) next_state = S_LOAD;
         S_ECHO:    if (cnt_last) next_state = (echo_cnt == num_q) ? S_FIN : S_LOAD;
         S_FIN:     next_state = S_IDLE;
         default:   next_state = S_IDLE;
      endcase
      if (abort) next_state = S_IDLE;
   end

   // Every transition below keys off next_state, so abort suppresses them all.
   always_ff @(posedge clk_sys) begin
      if (rst) begin
         t180_q   <= '0;
         bri_q    <= '0;
         tau_q    <= '0;
         num_q    <= '0;
         is180    <= 1'b0;
         dly_cnt  <= '0;
         to_cnt   <= '0;
         qq_para  <= '0;
         bri_para <= '0;
         phase    <= 1'b0;
         err      <= 1'b0;
         echo_cnt <= '0;
      end else begin
         if (state == S_IDLE && next_state == S_LOAD) begin
            t180_q   <= t180_len;
            bri_q    <= bri_cfg;
            tau_q    <= tau;
            num_q    <= echo_num;
            err      <= 1'b0;
            echo_cnt <= '0;
         end
         if (next_state == S_LOAD) begin
            if (state == S_IDLE) begin
               qq_para  <= t90_len;
               bri_para <= bri_cfg;
               phase    <= 1'b0;
               is180    <= 1'b0;
            end else begin
               qq_para  <= t180_q;
               bri_para <= bri_q;
               phase    <= 1'b1;
               is180    <= 1'b1;
            end
         end
         if (abort) phase <= 1'b0;
         case (state)
            S_FIRE:    to_cnt <= TO_W'(TO_CYC);
            S_WAIT_HI: begin
               if (to_cnt != '0) to_cnt <= to_cnt - TO_W'(1);
               if (next_state == S_FIN) err <= 1'b1;
            end
            S_WAIT_LO: begin
               if (next_state == S_ECHO) begin
                  echo_cnt <= echo_cnt + CNT_W'(1);
                  dly_cnt  <= tau2;
               end else if (next_state == S_DELAY) begin
                  dly_cnt  <= {1'b0, tau_eff};
               end
            end
            S_DELAY, S_ECHO: dly_cnt <= dly_cnt - (CNT_W+1)'(1);
            default: ;
         endcase
      end
   end

   // Strobes decode the state register only, so no input reaches an output combinationally.
   always_comb begin
      pluse_load  = (state == S_LOAD);
      state_start = (state == S_FIRE);
      acq_win     = (state == S_ECHO);
      busy        = (state != S_IDLE) && (state != S_FIN);
      done        = (state == S_FIN) && !err;
   end

endmodule

// File: tb/tb_pluse_seq_ctrl.sv
// Scoreboard bench for pluse_seq_ctrl: stimulus queues expected loads, echo windows
// and completions; a monitor pops and compares them as the DUT produces them.
module tb_pluse_seq_ctrl;

   logic        clk_sys = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic        abort = 1'b0;
   logic [15:0] t90_len = '0;
   logic [15:0] t180_len = '0;
   logic [7:0]  bri_cfg = '0;
   logic [15:0] tau = '0;
   logic [15:0] echo_num = '0;
   logic        pulse_busy = 1'b0;
   logic        pluse_load, state_start, phase, acq_win, busy, done, err;
   logic [15:0] qq_para, echo_cnt;
   logic [7:0]  bri_para;
   logic        model_en = 1'b1;

   int checks = 0;
   int errors = 0;

   typedef struct { logic [15:0] qq; logic ph; logic [7:0] bri; int gap; } load_t;
   typedef struct { logic [15:0] ecnt; int gap; } done_t;
   load_t load_q[$];
   int    acq_q[$];
   done_t done_q[$];

   pluse_seq_ctrl #(.QQ_W(16), .CNT_W(16), .TO_CYC(8)) dut (
      .clk_sys(clk_sys), .rst(rst), .start(start), .abort(abort),
      .t90_len(t90_len), .t180_len(t180_len), .bri_cfg(bri_cfg), .tau(tau),
      .echo_num(echo_num), .pulse_busy(pulse_busy), .pluse_load(pluse_load),
      .state_start(state_start), .phase(phase), .qq_para(qq_para),
      .bri_para(bri_para), .acq_win(acq_win), .busy(busy), .done(done),
      .err(err), .echo_cnt(echo_cnt)
   );

   always #5 clk_sys = ~clk_sys;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: actual=%0d required=%0d", name, act, exp);
      end
   endtask

   task automatic flag(input string name);
      checks++;
      errors++;
      $display("FAIL %s: condition not met", name);
   endtask

   // PLUSE stand-in: busy rises the cycle after state_start and stays high qq_para cycles
   initial begin
      int len;
      forever begin
         @(negedge clk_sys);
         if (state_start && model_en) begin
            len = int'(qq_para);
            @(posedge clk_sys); #1 pulse_busy = 1'b1;
            repeat (len) @(posedge clk_sys);
            #1 pulse_busy = 1'b0;
         end
      end
   end

   // Monitor: cycle numbers are negedge samples; gaps are measured from the
   // first sample that sees pulse_busy low after a pulse.
   initial begin
      int    cyc = 0;
      int    fall_cyc = 0;
      int    acq_len = 0;
      logic  prev_pb = 1'b0;
      logic  prev_acq = 1'b0;
      load_t le;
      done_t de;
      int    aw;
      forever begin
         @(negedge clk_sys);
         cyc++;
         if (prev_pb && !pulse_busy) fall_cyc = cyc;
         prev_pb = pulse_busy;
         if (pluse_load) begin
            if (load_q.size() == 0) flag("unexpected_load");
            else begin
               le = load_q.pop_front();
               check("load_qq", 32'(qq_para), 32'(le.qq));
               check("load_phase", 32'(phase), 32'(le.ph));
               check("load_bri", 32'(bri_para), 32'(le.bri));
               if (le.gap >= 0) check("load_gap", cyc - fall_cyc, le.gap);
            end
         end
         if (acq_win) begin
            if (!prev_acq) check("acq_start", cyc - fall_cyc, 1);
            acq_len++;
         end else if (prev_acq) begin
            if (acq_q.size() == 0) flag("unexpected_acq");
            else begin
               aw = acq_q.pop_front();
               check("acq_width", acq_len, aw);
            end
            acq_len = 0;
         end
         prev_acq = acq_win;
         if (done) begin
            if (done_q.size() == 0) flag("unexpected_done");
            else begin
               de = done_q.pop_front();
               check("done_echo_cnt", 32'(echo_cnt), 32'(de.ecnt));
               check("done_err", 32'(err), 0);
               check("done_busy", 32'(busy), 0);
               check("done_gap", cyc - fall_cyc, de.gap);
            end
         end
      end
   end

   task automatic push_train(input logic [15:0] a90, input logic [15:0] a180,
                             input logic [7:0] b, input int tu, input int n);
      int te;
      te = (tu == 0) ? 1 : tu;
      load_q.push_back('{a90, 1'b0, b, -1});
      for (int i = 0; i < n; i++) begin
         load_q.push_back('{a180, 1'b1, b, (i == 0) ? te + 1 : 2 * te + 1});
         acq_q.push_back(2 * te);
      end
      done_q.push_back('{16'(n), (n == 0) ? 1 : 2 * te + 1});
   endtask

   // Returns at the negedge inside the FIRE cycle; inputs are scrambled after the
   // start edge to prove the train runs from latched values.
   task automatic start_train(input logic [15:0] a90, input logic [15:0] a180,
                              input logic [7:0] b, input logic [15:0] tu, input logic [15:0] n);
      @(negedge clk_sys);
      t90_len = a90; t180_len = a180; bri_cfg = b; tau = tu; echo_num = n;
      start = 1'b1;
      @(posedge clk_sys); #1;
      start = 1'b0;
      t90_len = 16'hDEAD; t180_len = 16'hBEEF; bri_cfg = 8'h3C; tau = 16'd999; echo_num = 16'd77;
      @(negedge clk_sys);
      check("start_busy", 32'(busy), 1);
      check("start_err_clear", 32'(err), 0);
      check("start_echo_cnt_clear", 32'(echo_cnt), 0);
      check("start_load_cycle", 32'(pluse_load), 1);
      @(negedge clk_sys);
      check("start_fire_cycle", 32'(state_start), 1);
   endtask

   task automatic wait_idle(input int budget, input string name);
      int i = 0;
      while (busy && i < budget) begin @(negedge clk_sys); i++; end
      if (busy) flag(name);
      i = 0;
      while (pulse_busy && i < budget) begin @(negedge clk_sys); i++; end
      if (pulse_busy) flag(name);
      repeat (3) @(negedge clk_sys);
   endtask

   task automatic wait_acq(input logic val, input int budget, input string name);
      int i = 0;
      while (acq_win !== val && i < budget) begin @(negedge clk_sys); i++; end
      if (acq_win !== val) flag(name);
   endtask

   task automatic wait_pb(input logic val, input int budget, input string name);
      int i = 0;
      while (pulse_busy !== val && i < budget) begin @(negedge clk_sys); i++; end
      if (pulse_busy !== val) flag(name);
   endtask

   task automatic check_zero(input string tag);
      check({tag, "_pluse_load"}, 32'(pluse_load), 0);
      check({tag, "_state_start"}, 32'(state_start), 0);
      check({tag, "_phase"}, 32'(phase), 0);
      check({tag, "_qq_para"}, 32'(qq_para), 0);
      check({tag, "_bri_para"}, 32'(bri_para), 0);
      check({tag, "_acq_win"}, 32'(acq_win), 0);
      check({tag, "_busy"}, 32'(busy), 0);
      check({tag, "_done"}, 32'(done), 0);
      check({tag, "_err"}, 32'(err), 0);
      check({tag, "_echo_cnt"}, 32'(echo_cnt), 0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (3) @(posedge clk_sys);
      @(negedge clk_sys);
      rst = 1'b0;
      check_zero("reset");

      // basic train
      push_train(16'd20, 16'd40, 8'hA5, 10, 3);
      start_train(16'd20, 16'd40, 8'hA5, 16'd10, 16'd3);
      wait_idle(2000, "basic_timeout");

      // timeout: PLUSE never answers
      model_en = 1'b0;
      load_q.push_back('{16'd5, 1'b0, 8'h11, -1});
      start_train(16'd5, 16'd7, 8'h11, 16'd3, 16'd2);
      repeat (7) @(negedge clk_sys);
      @(negedge clk_sys);
      check("err_before_timeout", 32'(err), 0);
      @(negedge clk_sys);
      check("err_at_timeout", 32'(err), 1);
      check("timeout_busy", 32'(busy), 0);
      check("timeout_no_done", 32'(done), 0);
      @(negedge clk_sys);
      check("timeout_idle_busy", 32'(busy), 0);
      check("err_sticky", 32'(err), 1);
      model_en = 1'b1;
      wait_idle(100, "timeout_idle");

      // echo_num = 0; start also clears the sticky err
      push_train(16'd12, 16'd30, 8'h5A, 7, 0);
      start_train(16'd12, 16'd30, 8'h5A, 16'd7, 16'd0);
      wait_idle(500, "echo0_timeout");

      // tau = 0 behaves as tau = 1
      push_train(16'd6, 16'd9, 8'h0F, 0, 2);
      start_train(16'd6, 16'd9, 8'h0F, 16'd0, 16'd2);
      wait_idle(500, "tau0_timeout");

      // abort during the second echo window; a start during the first is ignored
      load_q.push_back('{16'd6, 1'b0, 8'hC3, -1});
      load_q.push_back('{16'd8, 1'b1, 8'hC3, 5});
      load_q.push_back('{16'd8, 1'b1, 8'hC3, 9});
      acq_q.push_back(8);
      acq_q.push_back(3);
      start_train(16'd6, 16'd8, 8'hC3, 16'd4, 16'd3);
      wait_acq(1'b1, 200, "abort_first_acq");
      start = 1'b1;
      @(posedge clk_sys); #1 start = 1'b0;
      wait_acq(1'b0, 200, "abort_first_acq_end");
      wait_acq(1'b1, 200, "abort_second_acq");
      repeat (2) @(negedge clk_sys);
      abort = 1'b1;
      @(posedge clk_sys); #1 abort = 1'b0;
      @(negedge clk_sys);
      check("abort_acq_win", 32'(acq_win), 0);
      check("abort_busy", 32'(busy), 0);
      check("abort_echo_cnt", 32'(echo_cnt), 2);
      check("abort_qq_hold", 32'(qq_para), 8);
      check("abort_bri_hold", 32'(bri_para), 32'h00C3);
      check("abort_phase", 32'(phase), 0);
      check("abort_no_done", 32'(done), 0);
      @(negedge clk_sys);
      check("abort_stays_idle", 32'(busy), 0);
      wait_idle(100, "abort_idle");

      // reset while waiting for the 90 deg pulse to end, then replay
      load_q.push_back('{16'd20, 1'b0, 8'h77, -1});
      start_train(16'd20, 16'd40, 8'h77, 16'd10, 16'd3);
      wait_pb(1'b1, 50, "midreset_pb_rise");
      @(negedge clk_sys);
      rst = 1'b1;
      @(posedge clk_sys); #1 rst = 1'b0;
      @(negedge clk_sys);
      check_zero("midreset");
      wait_pb(1'b0, 100, "midreset_pb_fall");
      repeat (2) @(negedge clk_sys);
      push_train(16'd20, 16'd40, 8'h77, 10, 3);
      start_train(16'd20, 16'd40, 8'h77, 16'd10, 16'd3);
      wait_idle(2000, "replay_timeout");

      check("load_q_drained", load_q.size(), 0);
      check("acq_q_drained", acq_q.size(), 0);
      check("done_q_drained", done_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
